booth_mul_arbiter: RTL and testbench

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

---
 rtl/booth_mul_arbiter.sv | 104 ++++++++++
 tb/tb_booth_mul_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Two requesters share one radix-4 Booth 8x8 signed multiplier; result shows 2 cycles after accept.
// Both ready lines are low while a result waits in HOLD for out_ready.
module booth_mul_arbiter #(
  parameter int Operand_Width = 8,
  parameter int Product_Width = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [Operand_Width-1:0] req0_multiplicand,
  input  logic [Operand_Width-1:0] req0_multiplier,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [Operand_Width-1:0] req1_multiplicand,
  input  logic [Operand_Width-1:0] req1_multiplier,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Product_Width-1:0] out_product,
  output logic                     out_id,
  output logic [15:0]              op_count
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t                   state;
  logic                     last_grant;
  logic [Operand_Width-1:0] mcand_q;
  logic [Operand_Width-1:0] mplier_q;
  logic                     id_q;
  logic                     grant0;
  logic                     grant1;

  // Ties go to the requester not served last; rst_n gating keeps ready low during reset.
  assign grant0 = (state == IDLE) && rst_n && req0_valid && (!req1_valid || last_grant);
  assign grant1 = (state == IDLE) && rst_n && req1_valid && !grant0;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  logic [Product_Width-1:0] mcand_ext;
  logic [Operand_Width:0]   mplier_ext;
  logic [Product_Width-1:0] pp;
  logic [Product_Width-1:0] booth_sum;

  assign mcand_ext  = {{(Product_Width-Operand_Width){mcand_q[Operand_Width-1]}}, mcand_q};
  assign mplier_ext = {mplier_q, 1'b0};

  // Radix-4 recoding: each overlapping 3-bit group selects 0, +-M or +-2M at weight 4^i.
  always_comb begin
    booth_sum = '0;
    pp        = '0;
    for (int i = 0; i < Operand_Width / 2; i++) begin
      case (mplier_ext[2*i +: 3])
        3'b001, 3'b010: pp = mcand_ext;
        3'b011:         pp = mcand_ext << 1;
        3'b100:         pp = -(mcand_ext << 1);
        3'b101, 3'b110: pp = -mcand_ext;
        default:        pp = '0;
      endcase
      booth_sum = booth_sum + (pp << (2*i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      mcand_q     <= '0;
      mplier_q    <= '0;
      id_q        <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_id      <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            mcand_q    <= grant1 ? req1_multiplicand : req0_multiplicand;
            mplier_q   <= grant1 ? req1_multiplier   : req0_multiplier;
            id_q       <= grant1;
            last_grant <= grant1;
            state      <= CALC;
          end
        end
        CALC: begin
          out_product <= booth_sum;
          out_id      <= id_q;
          out_valid   <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: reset, latency, arbitration, backpressure, corners, sweep, wrap.
module tb_booth_mul_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_multiplicand, req0_multiplier;
  logic [7:0]  req1_multiplicand, req1_multiplier;
  logic        out_valid, out_ready, out_id;
  logic [15:0] out_product, op_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]  q0a[$], q0b[$], q1a[$], q1b[$];
  logic [15:0] ex_prod[$];
  logic        ex_id[$];

  booth_mul_arbiter #(.Operand_Width(8), .Product_Width(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_multiplicand(req0_multiplicand), .req0_multiplier(req0_multiplier),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_multiplicand(req1_multiplicand), .req1_multiplier(req1_multiplier),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_id(out_id), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    req0_valid = (q0a.size() > 0);
    req1_valid = (q1a.size() > 0);
    if (req0_valid) begin req0_multiplicand = q0a[0]; req0_multiplier = q0b[0]; end
    if (req1_valid) begin req1_multiplicand = q1a[0]; req1_multiplier = q1b[0]; end
  endtask

  task automatic push_exp(input logic id, input logic [15:0] prod);
    ex_id.push_back(id);
    ex_prod.push_back(prod);
  endtask

  // Feeds the request queues and checks every result against the expected queue, in order.
  task automatic drain(input int n, input string tag);
    int got = 0;
    int cyc = 0;
    logic a0, a1;
    drive_reqs();
    while (got < n && cyc < 4*n + 20) begin
      @(negedge clk);
      chk({tag, "_excl"}, 32'(req0_ready & req1_ready), 0);
      a0 = req0_ready;
      a1 = req1_ready;
      if (out_valid) begin
        chk({tag, "_hold_rdy"}, {req0_ready, req1_ready}, 0);
        if (ex_prod.size() == 0) begin
          chk({tag, "_extra_result"}, 1, 0);
        end else begin
          chk({tag, "_prod"}, out_product, ex_prod.pop_front());
          chk({tag, "_id"}, out_id, ex_id.pop_front());
        end
        got++;
      end
      @(posedge clk); #1;
      if (a0) begin void'(q0a.pop_front()); void'(q0b.pop_front()); end
      if (a1) begin void'(q1a.pop_front()); void'(q1b.pop_front()); end
      drive_reqs();
      cyc++;
    end
    chk({tag, "_count"}, got, n);
  endtask

  initial begin
    logic signed [7:0]  ra, rb;
    logic signed [15:0] rp;

    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_multiplicand = 8'd3; req0_multiplier = 8'hFB;
    req1_multiplicand = '0;   req1_multiplier = '0;
    out_ready = 1'b1;

    // Reset state, ready held low while in reset
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_prod", out_product, 0);
    chk("rst_id", out_id, 0);
    chk("rst_count", op_count, 0);
    chk("rst_ready0", req0_ready, 0);

    // Single op: 3 * -5
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    @(posedge clk); #1; req0_valid = 1'b0;
    @(negedge clk);
    chk("single_calc_valid", out_valid, 0);
    chk("single_calc_ready0", req0_ready, 0);
    @(negedge clk);
    chk("single_valid", out_valid, 1);
    chk("single_prod", out_product, 16'hFFF1);
    chk("single_id", out_id, 0);
    chk("single_count_before", op_count, 0);
    @(negedge clk);
    chk("single_valid_low", out_valid, 0);
    chk("single_count", op_count, 1);
    chk("single_prod_retained", out_product, 16'hFFF1);

    // Contention from a fresh reset; req0 re-presents immediately after its grant
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    q0a = '{8'd7, 8'd2};  q0b = '{8'd9, 8'd3};
    q1a = '{8'h80};       q1b = '{8'h80};
    push_exp(1'b0, 16'h003F);
    push_exp(1'b1, 16'h4000);
    push_exp(1'b0, 16'h0006);
    drain(3, "cont");
    // Fresh simultaneous pair: requester 0 was served last, so requester 1 wins
    q0a = '{8'd5};  q0b = '{8'd5};
    q1a = '{8'hFE}; q1b = '{8'd3};
    push_exp(1'b1, 16'hFFFA);
    push_exp(1'b0, 16'h0019);
    drain(2, "pair2");
    chk("pair2_count", op_count, 5);

    // Backpressure: -128 * 127 held for 10 cycles
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_multiplicand = 8'h80; req0_multiplier = 8'h7F;
    @(negedge clk);
    chk("bp_ready0", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_multiplicand = 8'd4; req1_multiplier = 8'hFC;
    @(negedge clk);
    chk("bp_calc_ready1", req1_ready, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_prod", out_product, 16'hC080);
      chk("bp_id", out_id, 0);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
      chk("bp_count", op_count, 5);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", out_valid, 1);
    chk("bp_hs_ready1", req1_ready, 0);
    @(negedge clk);
    chk("bp_after_valid", out_valid, 0);
    chk("bp_after_count", op_count, 6);
    chk("bp_after_prod", out_product, 16'hC080);
    chk("bp_after_ready1", req1_ready, 1);
    @(posedge clk); #1; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_r1_valid", out_valid, 1);
    chk("bp_r1_prod", out_product, 16'hFFF0);
    chk("bp_r1_id", out_id, 1);
    @(posedge clk); #1;

    // Corners then a random sweep against a signed reference
    q0a = '{8'h7F, 8'h00, 8'hFF}; q0b = '{8'h7F, 8'h80, 8'hFF};
    push_exp(1'b0, 16'h3F01);
    push_exp(1'b0, 16'h0000);
    push_exp(1'b0, 16'h0001);
    for (int k = 0; k < 2000; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = ra * rb;
      q0a.push_back(ra);
      q0b.push_back(rb);
      push_exp(1'b0, rp);
    end
    drain(2003, "sweep");
    chk("sweep_count", op_count, 2010);
    q1a = '{8'd6}; q1b = '{8'hF9};
    push_exp(1'b1, 16'hFFD6);
    drain(1, "r1op");

    // Asynchronous reset while in CALC
    req0_valid = 1'b1; req0_multiplicand = 8'd9; req0_multiplier = 8'd9;
    @(negedge clk);
    chk("mid_ready0", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_multiplicand = 8'hFD; req1_multiplier = 8'd5;
    #1; rst_n = 1'b0; #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_prod", out_product, 0);
    chk("mid_id", out_id, 0);
    chk("mid_count", op_count, 0);
    chk("mid_ready1", req1_ready, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    q1a = '{8'hFD}; q1b = '{8'd5};
    push_exp(1'b1, 16'hFFF1);
    drain(1, "mid_rec");
    chk("mid_rec_count", op_count, 1);

    // Count wrap from a preloaded value
    force dut.op_count = 16'hFFFE;
    #1; release dut.op_count;
    q0a = '{8'd1}; q0b = '{8'd1};
    push_exp(1'b0, 16'h0001);
    drain(1, "wrap1");
    chk("wrap_ffff", op_count, 16'hFFFF);
    q0a = '{8'd2}; q0b = '{8'd2};
    push_exp(1'b0, 16'h0004);
    drain(1, "wrap2");
    chk("wrap_zero", op_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
